// File: rtl/uart_rx_os16.sv
// 16x-oversampled UART receiver: start/mid-bit sampling, stop check, valid/ack handshake.
// Optional parity bit and parity_err pulse are compiled in with `define UART_RX_PARITY_EN.
module uart_rx_os16 #(
    parameter int DATA_BITS  = 8,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 os_tick,
    input  logic                 rx,
    input  logic                 rx_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 overrun_err,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 busy
);

    localparam int             BCW      = $clog2(DATA_BITS + 1);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_BITS - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_STOP   = 3'd3;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd4;
    localparam logic [2:0] AFTER_DATA = ST_PARITY;

    function automatic logic parity_fail(input logic [DATA_BITS-1:0] d, input logic p, input logic odd);
        return ((^d) ^ p) != odd;
    endfunction
`else
    localparam logic [2:0] AFTER_DATA = ST_STOP;

    logic parity_unused_s;
    assign parity_unused_s = PARITY_ODD;
`endif

    logic                 sync1_r;
    logic                 rx_s;
    logic [2:0]           state_r, state_nxt;
    logic [3:0]           os_cnt_r, os_cnt_nxt;
    logic [BCW-1:0]       bit_cnt_r, bit_cnt_nxt;
    logic [DATA_BITS-1:0] shreg_r, shreg_nxt;
    logic                 armed_r, armed_nxt;
    logic [DATA_BITS-1:0] data_nxt;
    logic                 valid_nxt, ferr_nxt, oerr_nxt;
`ifdef UART_RX_PARITY_EN
    logic                 par_bit_r, par_bit_nxt, perr_nxt;
`endif

    // Two-flop synchronizer; idles high so reset does not look like a start bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_r <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            sync1_r <= rx;
            rx_s    <= sync1_r;
        end
    end

    // Frame sequencing and handshake decisions; counters only move on os_tick.
    always_comb begin
        state_nxt   = state_r;
        os_cnt_nxt  = os_cnt_r;
        bit_cnt_nxt = bit_cnt_r;
        shreg_nxt   = shreg_r;
        armed_nxt   = armed_r;
        data_nxt    = rx_data;
        ferr_nxt    = 1'b0;
        oerr_nxt    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_nxt = par_bit_r;
        perr_nxt    = 1'b0;
`endif
        if (rx_ack && rx_valid) begin
            valid_nxt = 1'b0;
        end else begin
            valid_nxt = rx_valid;
        end

        case (state_r)
            ST_IDLE: begin
                if (rx_s) begin
                    armed_nxt = 1'b1;
                end else if (os_tick && armed_r) begin
                    state_nxt  = ST_START;
                    os_cnt_nxt = 4'd0;
                    armed_nxt  = 1'b0;
                end else begin
                    armed_nxt = armed_r;
                end
            end
            ST_START: begin
                if (!os_tick) begin
                    os_cnt_nxt = os_cnt_r;
                end else if (os_cnt_r == 4'd7) begin
                    os_cnt_nxt  = 4'd0;
                    bit_cnt_nxt = '0;
                    if (!rx_s) begin
                        state_nxt = ST_DATA;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    os_cnt_nxt = os_cnt_r + 4'd1;
                end
            end
            ST_DATA: begin
                if (!os_tick) begin
                    os_cnt_nxt = os_cnt_r;
                end else if (os_cnt_r == 4'd15) begin
                    shreg_nxt   = {rx_s, shreg_r[DATA_BITS-1:1]};
                    os_cnt_nxt  = 4'd0;
                    bit_cnt_nxt = bit_cnt_r + BCW'(1);
                    if (bit_cnt_r == LAST_BIT) begin
                        state_nxt = AFTER_DATA;
                    end else begin
                        state_nxt = ST_DATA;
                    end
                end else begin
                    os_cnt_nxt = os_cnt_r + 4'd1;
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (!os_tick) begin
                    os_cnt_nxt = os_cnt_r;
                end else if (os_cnt_r == 4'd15) begin
                    par_bit_nxt = rx_s;
                    os_cnt_nxt  = 4'd0;
                    state_nxt   = ST_STOP;
                end else begin
                    os_cnt_nxt = os_cnt_r + 4'd1;
                end
            end
`endif
            ST_STOP: begin
                if (!os_tick) begin
                    os_cnt_nxt = os_cnt_r;
                end else if (os_cnt_r == 4'd15) begin
                    state_nxt  = ST_IDLE;
                    os_cnt_nxt = 4'd0;
`ifdef UART_RX_PARITY_EN
                    perr_nxt   = parity_fail(shreg_r, par_bit_r, PARITY_ODD);
`endif
                    // A good stop always delivers; an ack in the same cycle only suppresses overrun.
                    if (rx_s) begin
                        data_nxt  = shreg_r;
                        valid_nxt = 1'b1;
                        oerr_nxt  = rx_valid & ~rx_ack;
                    end else begin
                        ferr_nxt = 1'b1;
                    end
                end else begin
                    os_cnt_nxt = os_cnt_r + 4'd1;
                end
            end
            default: begin
                state_nxt  = ST_IDLE;
                os_cnt_nxt = 4'd0;
                armed_nxt  = 1'b0;
            end
        endcase
    end

    // State, counters and registered host-side outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            os_cnt_r    <= 4'd0;
            bit_cnt_r   <= '0;
            shreg_r     <= '0;
            armed_r     <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
            busy        <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_r   <= 1'b0;
            parity_err  <= 1'b0;
`endif
        end else begin
            state_r     <= state_nxt;
            os_cnt_r    <= os_cnt_nxt;
            bit_cnt_r   <= bit_cnt_nxt;
            shreg_r     <= shreg_nxt;
            armed_r     <= armed_nxt;
            rx_data     <= data_nxt;
            rx_valid    <= valid_nxt;
            frame_err   <= ferr_nxt;
            overrun_err <= oerr_nxt;
            busy        <= (state_nxt != ST_IDLE);
`ifdef UART_RX_PARITY_EN
            par_bit_r   <= par_bit_nxt;
            parity_err  <= perr_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_uart_rx_os16.sv
// Randomized self-checking bench for uart_rx_os16 against a frame-level reference model.
// Honors UART_RX_PARITY_EN in the same way as the design.
module tb_uart_rx_os16;

    localparam bit PARITY_ODD = 1'b0;
`ifdef UART_RX_PARITY_EN
    localparam int NPAR = 1;
`else
    localparam int NPAR = 0;
`endif
    // Ticks from the tick coinciding with the start edge to the stop-bit sample.
    localparam int STOP_OFS  = 1 + 8 + 16 * (8 + NPAR + 1);
    localparam int BUSY_CLKS = 4 * (STOP_OFS - 1);

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       os_tick = 1'b0;
    logic       rx = 1'b1;
    logic       rx_ack = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, overrun_err, busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    uart_rx_os16 #(.DATA_BITS(8), .PARITY_ODD(PARITY_ODD)) dut (
        .clk(clk), .rst_n(rst_n), .os_tick(os_tick), .rx(rx), .rx_ack(rx_ack),
        .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
        .overrun_err(overrun_err),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int phase = 0, tick_num = 0, ack_tick = -1, cyc = 0;
    bit ack_manual = 1'b0;
    int ferr_seen = 0, oerr_seen = 0, perr_seen = 0;
    int busy_rise = 0, busy_fall = 0, valid_rise = 0;
    bit prev_busy = 1'b0, prev_valid = 1'b0;

    // Reference model state
    bit       m_valid = 1'b0;
    bit [7:0] m_data = 8'h00;
    int       m_ferr = 0, m_oerr = 0, m_perr = 0;

    task automatic step();
        @(negedge clk);
        cyc++;
        if (frame_err) ferr_seen++;
        if (overrun_err) oerr_seen++;
`ifdef UART_RX_PARITY_EN
        if (parity_err) perr_seen++;
`endif
        if (busy && !prev_busy) busy_rise = cyc;
        if (!busy && prev_busy) busy_fall = cyc;
        if (rx_valid && !prev_valid) valid_rise = cyc;
        prev_busy  = busy;
        prev_valid = rx_valid;
        phase   = (phase + 1) % 4;
        os_tick = (phase == 0);
        if (os_tick) tick_num++;
        rx_ack = ack_manual || (os_tick && tick_num == ack_tick);
    endtask

    task automatic do_ack();
        ack_manual = 1'b1;
        step();
        ack_manual = 1'b0;
        step();
        step();
        m_valid = 1'b0;
    endtask

    task automatic send_frame(input bit [7:0] d, input bit stop_ok, input bit pf,
                              input bit ack_at_stop, input int gap);
        bit pbit;
        pbit = bit'($countones(d) % 2) ^ PARITY_ODD ^ pf;
        do step(); while (!os_tick);
        ack_tick = ack_at_stop ? tick_num + STOP_OFS : -1;
        rx = 1'b0;
        repeat (64) step();
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (64) step();
        end
        if (NPAR == 1) begin
            rx = pbit;
            repeat (64) step();
        end
        rx = stop_ok;
        repeat (64) step();
        ack_tick = -1;
        rx = 1'b1;
        repeat (gap) step();
    endtask

    task automatic model_frame(input bit [7:0] d, input bit stop_ok, input bit pf, input bit ack_at_stop);
        bit pbit;
        pbit = bit'($countones(d) % 2) ^ PARITY_ODD ^ pf;
        if (NPAR == 1 && ((($countones(d) + int'(pbit)) % 2) != int'(PARITY_ODD))) m_perr++;
        if (stop_ok) begin
            if (m_valid && !ack_at_stop) m_oerr++;
            m_valid = 1'b1;
            m_data  = d;
        end else begin
            m_ferr++;
            if (ack_at_stop) m_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", rx_valid); end
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", rx_data); end
        total++; if ({frame_err, overrun_err, busy} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {frame_err, overrun_err, busy}); end
        rst_n = 1'b1;
        repeat (8) step();
    endtask

    task automatic test_basic();
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 8);
        model_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        total++; if (rx_valid !== m_valid) begin bad++; $display("FAIL basic_valid: got %0b want %0b", rx_valid, m_valid); end
        total++; if (rx_data !== m_data) begin bad++; $display("FAIL basic_data: got %h want %h", rx_data, m_data); end
        total++; if (ferr_seen != m_ferr || oerr_seen != m_oerr) begin bad++; $display("FAIL basic_errs: got f=%0d o=%0d want f=%0d o=%0d", ferr_seen, oerr_seen, m_ferr, m_oerr); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_idle: got %0b want 0", busy); end
        total++; if (busy_fall - busy_rise != BUSY_CLKS) begin bad++; $display("FAIL basic_busy_len: got %0d want %0d", busy_fall - busy_rise, BUSY_CLKS); end
        total++; if (valid_rise != busy_fall) begin bad++; $display("FAIL basic_valid_timing: got %0d want %0d", valid_rise, busy_fall); end
        do_ack();
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL basic_ack: got %0b want 0", rx_valid); end
    endtask

    task automatic test_glitch();
        rx = 1'b0;
        repeat (12) step();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL glitch_busy: got %0b want 1", busy); end
        rx = 1'b1;
        repeat (60) step();
        total++; if (busy !== 1'b0 || rx_valid !== 1'b0) begin bad++; $display("FAIL glitch_idle: got busy=%0b valid=%0b want 0 0", busy, rx_valid); end
        total++; if (ferr_seen != m_ferr) begin bad++; $display("FAIL glitch_ferr: got %0d want %0d", ferr_seen, m_ferr); end
        total++; if (busy_fall - busy_rise != 32) begin bad++; $display("FAIL glitch_len: got %0d want 32", busy_fall - busy_rise); end
    endtask

    task automatic test_framing();
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 40);
        model_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        total++; if (ferr_seen != m_ferr) begin bad++; $display("FAIL frame_pulse: got %0d want %0d", ferr_seen, m_ferr); end
        total++; if (rx_valid !== m_valid) begin bad++; $display("FAIL frame_valid: got %0b want %0b", rx_valid, m_valid); end
        send_frame(8'h81, 1'b1, 1'b0, 1'b0, 8);
        model_frame(8'h81, 1'b1, 1'b0, 1'b0);
        total++; if (rx_valid !== m_valid || rx_data !== m_data) begin bad++; $display("FAIL frame_next: got %0b/%h want %0b/%h", rx_valid, rx_data, m_valid, m_data); end
    endtask

    task automatic test_back_to_back();
        do_ack();
        send_frame(8'h11, 1'b1, 1'b0, 1'b0, 0);
        model_frame(8'h11, 1'b1, 1'b0, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0, 4);
        model_frame(8'h22, 1'b1, 1'b0, 1'b0);
        total++; if (oerr_seen != m_oerr) begin bad++; $display("FAIL b2b_overrun: got %0d want %0d", oerr_seen, m_oerr); end
        total++; if (rx_valid !== m_valid || rx_data !== m_data) begin bad++; $display("FAIL b2b_data: got %0b/%h want %0b/%h", rx_valid, rx_data, m_valid, m_data); end
        do_ack();
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL b2b_ack: got %0b want 0", rx_valid); end
    endtask

    task automatic test_ack_collision();
        send_frame(8'h11, 1'b1, 1'b0, 1'b0, 4);
        model_frame(8'h11, 1'b1, 1'b0, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0, 1'b1, 4);
        model_frame(8'h22, 1'b1, 1'b0, 1'b1);
        total++; if (rx_valid !== m_valid || rx_data !== m_data) begin bad++; $display("FAIL coll_data: got %0b/%h want %0b/%h", rx_valid, rx_data, m_valid, m_data); end
        total++; if (oerr_seen != m_oerr) begin bad++; $display("FAIL coll_overrun: got %0d want %0d", oerr_seen, m_oerr); end
    endtask

    task automatic test_reset_mid();
        bit [7:0] d = 8'h5A;
        do step(); while (!os_tick);
        rx = 1'b0;
        repeat (64) step();
        for (int i = 0; i < 4; i++) begin
            rx = d[i];
            repeat (64) step();
        end
        total++; if (busy !== 1'b1 || rx_valid !== 1'b1) begin bad++; $display("FAIL mid_pre: got busy=%0b valid=%0b want 1 1", busy, rx_valid); end
        rst_n = 1'b0;
        step();
        total++; if ({rx_valid, busy, frame_err, overrun_err} !== 4'b0000 || rx_data !== 8'h00) begin bad++; $display("FAIL mid_reset: got %b/%h want 0000/00", {rx_valid, busy, frame_err, overrun_err}, rx_data); end
        m_valid = 1'b0;
        m_data  = 8'h00;
        rx = 1'b1;
        repeat (4) step();
        rst_n = 1'b1;
        repeat (20) step();
        send_frame(8'h5A, 1'b1, 1'b1, 1'b0, 8);
        model_frame(8'h5A, 1'b1, 1'b1, 1'b0);
        total++; if (rx_valid !== m_valid || rx_data !== m_data) begin bad++; $display("FAIL mid_next: got %0b/%h want %0b/%h", rx_valid, rx_data, m_valid, m_data); end
        total++; if (perr_seen != m_perr || ferr_seen != m_ferr || oerr_seen != m_oerr) begin bad++; $display("FAIL mid_errs: got p=%0d f=%0d o=%0d want p=%0d f=%0d o=%0d", perr_seen, ferr_seen, oerr_seen, m_perr, m_ferr, m_oerr); end
    endtask

    task automatic test_random();
        bit [7:0] d;
        bit good, pf, acks;
        for (int i = 0; i < 8; i++) begin
            d    = 8'($urandom);
            good = ($urandom_range(0, 3) != 0);
            pf   = ($urandom_range(0, 2) == 0);
            acks = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1) do_ack();
            send_frame(d, good, pf, acks, $urandom_range(0, 30));
            model_frame(d, good, pf, acks);
            total++; if (rx_valid !== m_valid || rx_data !== m_data) begin bad++; $display("FAIL rand%0d_data: got %0b/%h want %0b/%h", i, rx_valid, rx_data, m_valid, m_data); end
            total++; if (ferr_seen != m_ferr || oerr_seen != m_oerr || perr_seen != m_perr) begin bad++; $display("FAIL rand%0d_errs: got f=%0d o=%0d p=%0d want f=%0d o=%0d p=%0d", i, ferr_seen, oerr_seen, perr_seen, m_ferr, m_oerr, m_perr); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_framing();
        test_back_to_back();
        test_ack_collision();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
